instr_stream_encoder: RTL and testbench

Sequential MIPS instruction encoder and instruction-memory loader: the writer end of the op/func/rs/rt/rd/imm fields the datapath controller decodes. It accepts one symbolic instruction per valid/ready handshake, packs it into a 32-bit MIPS word, and writes it to consecutive instruction-memory words starting at a base address. Test benches and boot logic use it to load programs for the single-cycle CPU.

---
 rtl/instr_stream_encoder.sv | 127 ++++++++++++
 tb/tb_instr_stream_encoder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_stream_encoder.sv
// Packs symbolic MIPS instructions into 32-bit words and streams them into
// consecutive instruction-memory words from BASE_ADDR, one per handshake.
module instr_stream_encoder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int unsigned CW        = 11
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          finish_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [3:0]    kind_i,
  input  logic [4:0]    rs_i,
  input  logic [4:0]    rt_i,
  input  logic [4:0]    rd_i,
  input  logic [15:0]   imm_i,
  input  logic [25:0]   target_i,
  output logic          im_we_o,
  output logic [31:0]   im_addr_o,
  output logic [31:0]   im_wdata_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          err_o
);

  localparam logic [CW-1:0] DepthCw = CW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StLoad, StFull} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   ptr_q, ptr_d;
  logic          err_q, err_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic [31:0]   enc_word;
  logic          enc_legal;
  logic          xfer;

  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b1;
    case (kind_i)
      4'd0:    enc_word = 32'h0;
      4'd1:    enc_word = {6'b000000, rs_i, rt_i, rd_i, 5'b00000, 6'b100001};
      4'd2:    enc_word = {6'b000000, rs_i, rt_i, rd_i, 5'b00000, 6'b100011};
      4'd3:    enc_word = {6'b000000, rs_i, 15'b0, 6'b001000};
      4'd4:    enc_word = {6'b001101, rs_i, rt_i, imm_i};
      4'd5:    enc_word = {6'b100011, rs_i, rt_i, imm_i};
      4'd6:    enc_word = {6'b101011, rs_i, rt_i, imm_i};
      4'd7:    enc_word = {6'b000100, rs_i, rt_i, imm_i};
      4'd8:    enc_word = {6'b001111, 5'b00000, rt_i, imm_i};
      4'd9:    enc_word = {6'b000011, target_i};
      default: enc_legal = 1'b0;
    endcase
  end

  assign full_o     = (count_q == DepthCw);
  assign in_ready_o = (state_q == StLoad) && !full_o;
  assign xfer       = in_valid_i && in_ready_o;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    // start wins over a same-cycle transfer or finish; the transfer is dropped
    if (start_i) begin
      state_d = StLoad;
      count_d = '0;
      err_d   = 1'b0;
      ptr_d   = BASE_ADDR;
    end else begin
      if (xfer) begin
        if (enc_legal) begin
          we_d    = 1'b1;
          addr_d  = ptr_q;
          wdata_d = enc_word;
          ptr_d   = ptr_q + 32'd4;
          count_d = count_q + CW'(1);
          if (count_q == DepthCw - CW'(1)) begin
            state_d = StFull;
          end
        end else begin
          err_d = 1'b1;
        end
      end
      if (finish_i) begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      count_q <= '0;
      ptr_q   <= BASE_ADDR;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign im_we_o    = we_q;
  assign im_addr_o  = addr_q;
  assign im_wdata_o = wdata_q;
  assign count_o    = count_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Scoreboard bench for instr_stream_encoder: a session-level reference model
// predicts every memory write; a negedge monitor compares what the DUT emits.
module tb_instr_stream_encoder;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 4;
  localparam logic [31:0] BASE  = 32'h0000_3000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, finish, in_valid, in_ready;
  logic [3:0]    kind;
  logic [4:0]    rs, rt, rd;
  logic [15:0]   imm;
  logic [25:0]   target;
  logic          im_we;
  logic [31:0]   im_addr, im_wdata;
  logic [CW-1:0] count;
  logic          full, err;

  always #5 clk = ~clk;

  instr_stream_encoder #(
    .DEPTH    (DEPTH),
    .BASE_ADDR(BASE),
    .CW       (CW)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .finish_i   (finish),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .kind_i     (kind),
    .rs_i       (rs),
    .rt_i       (rt),
    .rd_i       (rd),
    .imm_i      (imm),
    .target_i   (target),
    .im_we_o    (im_we),
    .im_addr_o  (im_addr),
    .im_wdata_o (im_wdata),
    .count_o    (count),
    .full_o     (full),
    .err_o      (err)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference encoding from the instruction-format rules, built with shifts.
  function automatic logic [31:0] ref_word(input int unsigned k, input int unsigned a_rs,
                                           input int unsigned a_rt, input int unsigned a_rd,
                                           input int unsigned a_imm, input int unsigned a_tgt);
    int unsigned r, i;
    r = (a_rs << 21) | (a_rt << 16);
    i = r | a_imm;
    case (k)
      1:       return r | (a_rd << 11) | 33;
      2:       return r | (a_rd << 11) | 35;
      3:       return (a_rs << 21) | 8;
      4:       return (32'd13 << 26) | i;
      5:       return (32'd35 << 26) | i;
      6:       return (32'd43 << 26) | i;
      7:       return (32'd4 << 26) | i;
      8:       return (32'd15 << 26) | (a_rt << 16) | a_imm;
      9:       return (32'd3 << 26) | a_tgt;
      default: return 32'h0;
    endcase
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int unsigned m_mode;  // 0 idle, 1 loading, 2 memory full
  int unsigned m_cnt;
  logic [31:0] m_ptr;
  bit          m_err;
  bit          exp_we;
  bit          checking = 1'b0;

  // Reference model: reacts to the inputs sampled at each rising edge.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_mode = 0; m_cnt = 0; m_ptr = BASE; m_err = 0; exp_we = 0;
        sb.delete();
      end else begin
        bit rdy;
        rdy    = (m_mode == 1) && (m_cnt < DEPTH);
        exp_we = 0;
        if (start) begin
          m_mode = 1; m_cnt = 0; m_err = 0; m_ptr = BASE;
        end else begin
          if (in_valid && rdy) begin
            if (kind <= 9) begin
              sb.push_back('{m_ptr, ref_word(kind, rs, rt, rd, imm, target)});
              m_ptr  = m_ptr + 4;
              m_cnt  = m_cnt + 1;
              exp_we = 1;
              if (m_cnt == DEPTH) m_mode = 2;
            end else begin
              m_err = 1;
            end
          end
          if (finish) m_mode = 0;
        end
      end
    end
  end

  // Monitor: compares DUT outputs with the model away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && checking) begin
        chk("in_ready", in_ready, (m_mode == 1) && (m_cnt < DEPTH));
        chk("count", count, m_cnt);
        chk("full", full, m_cnt == DEPTH);
        chk("err", err, m_err);
        chk("im_we", im_we, exp_we);
        if (im_we || exp_we) begin
          if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("im_addr", im_addr, e.addr);
            chk("im_wdata", im_wdata, e.data);
          end
        end
      end
    end
  end

  task automatic drv(input bit st, input bit fin, input bit v, input int unsigned k,
                     input int unsigned a_rs, input int unsigned a_rt, input int unsigned a_rd,
                     input int unsigned a_imm, input int unsigned a_tgt);
    start    = st;
    finish   = fin;
    in_valid = v;
    kind     = k[3:0];
    rs       = a_rs[4:0];
    rt       = a_rt[4:0];
    rd       = a_rd[4:0];
    imm      = a_imm[15:0];
    target   = a_tgt[25:0];
    @(negedge clk);
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ins(input int unsigned k, input int unsigned a_rs, input int unsigned a_rt,
                     input int unsigned a_rd, input int unsigned a_imm, input int unsigned a_tgt);
    drv(0, 0, 1, k, a_rs, a_rt, a_rd, a_imm, a_tgt);
  endtask

  task automatic chk_write(input string name, input logic [31:0] a, input logic [31:0] w);
    chk({name, "_we"}, im_we, 1);
    chk({name, "_addr"}, im_addr, a);
    chk({name, "_data"}, im_wdata, w);
  endtask

  logic [31:0] seq_words[5];

  initial begin
    seq_words = '{32'h3401_1234, 32'h3C08_ABCD, 32'h03E0_0008, 32'h1022_FFFF, 32'h0C00_0C03};
    rst_n = 1'b0;
    start = 0; finish = 0; in_valid = 0; kind = 0;
    rs = 0; rt = 0; rd = 0; imm = 0; target = 0;
    repeat (2) @(negedge clk);
    chk("rst_we", im_we, 0);
    chk("rst_addr", im_addr, 0);
    chk("rst_wdata", im_wdata, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", in_ready, 0);
    rst_n    = 1'b1;
    checking = 1'b1;
    idle();

    // First write after start
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    ins(1, 1, 2, 3, 0, 0);
    chk_write("addu", 32'h3000, 32'h0022_1821);
    chk("addu_count", count, 1);

    // Back-to-back sequence from a fresh session
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    ins(4, 0, 1, 0, 16'h1234, 0);
    chk_write("seq0", 32'h3000, seq_words[0]);
    ins(8, 0, 8, 0, 16'hABCD, 0);
    chk_write("seq1", 32'h3004, seq_words[1]);
    ins(3, 31, 0, 0, 0, 0);
    chk_write("seq2", 32'h3008, seq_words[2]);
    ins(7, 1, 2, 0, 16'hFFFF, 0);
    chk_write("seq3", 32'h300C, seq_words[3]);
    ins(9, 0, 0, 0, 0, 26'hC03);
    chk_write("seq4", 32'h3010, seq_words[4]);

    // Illegal kind mid-stream
    ins(12, 3, 4, 5, 16'h5555, 0);
    chk("ill_we", im_we, 0);
    chk("ill_count", count, 5);
    chk("ill_err", err, 1);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("restart_err", err, 0);
    chk("restart_count", count, 0);
    ins(0, 0, 0, 0, 0, 0);
    chk_write("restart_nop", 32'h3000, 32'h0);

    // Fill the memory; the extra instruction is held off
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH + 1; i++) ins(2, i, i + 1, i + 2, 0, 0);
    idle();
    chk("full_flag", full, 1);
    chk("full_ready", in_ready, 0);
    chk("full_count", count, DEPTH);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    ins(1, 7, 8, 9, 0, 0);
    chk_write("after_full", 32'h3000, ref_word(1, 7, 8, 9, 0, 0));

    // start beats a same-cycle transfer; transfer with finish still writes
    drv(1, 0, 1, 1, 1, 1, 1, 0, 0);
    chk("start_drop_we", im_we, 0);
    chk("start_drop_count", count, 0);
    drv(0, 1, 1, 4, 2, 3, 0, 16'h00FF, 0);
    chk_write("finish_xfer", 32'h3000, 32'h3443_00FF);
    chk("finish_ready", in_ready, 0);
    idle();

    // Reset while streaming
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) ins(1, 4, 5, 6, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_we", im_we, 0);
    chk("arst_addr", im_addr, 0);
    chk("arst_wdata", im_wdata, 0);
    chk("arst_count", count, 0);
    chk("arst_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_we", im_we, 0);
    idle();

    // Randomized sessions
    for (int n = 0; n < 3000; n++) begin
      int unsigned r, k;
      r = $urandom_range(19);
      k = (r < 10) ? r : $urandom_range(15);
      drv(($urandom_range(31) == 0), ($urandom_range(31) == 0), ($urandom_range(3) != 0), k,
          $urandom, $urandom, $urandom, $urandom, $urandom);
    end
    repeat (3) idle();
    chk("sb_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
